// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types, FIPS 180-4 initial hash value and FSM encoding
// for the SHA-256 compression core.
package sha256_pkg;
    typedef logic [31:0] word_t;

    localparam int ROUNDS_DEFAULT = 64;

    localparam word_t IV0 = 32'h6a09e667;
    localparam word_t IV1 = 32'hbb67ae85;
    localparam word_t IV2 = 32'h3c6ef372;
    localparam word_t IV3 = 32'ha54ff53a;
    localparam word_t IV4 = 32'h510e527f;
    localparam word_t IV5 = 32'h9b05688c;
    localparam word_t IV6 = 32'h1f83d9ab;
    localparam word_t IV7 = 32'h5be0cd19;
    localparam logic [255:0] IV = {IV0, IV1, IV2, IV3, IV4, IV5, IV6, IV7};

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 round; a..h packed with a in the MSBs.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] vars_in,
    input  word_t        w,
    input  word_t        k,
    output logic [255:0] vars_out
);
    word_t a, b, c, d, e, f, g, h, t1, t2;

    always_comb begin
        {a, b, c, d, e, f, g, h} = vars_in;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        vars_out = {t1 + t2, a, b, c, d + t1, e, f, g};
    end
endmodule

// File: rtl/sha256_compress.sv
// sha256_compress: iterative SHA-256 block compression, one round per accepted
// W/K pair, with chaining through the digest register.
module sha256_compress
    import sha256_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         first_block,
    input  logic         w_valid,
    input  word_t        w_in,
    input  word_t        k_in,
    output logic         w_ready,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest,
    output logic [6:0]   round
);
    state_t       state_q, state_d;
    logic [6:0]   round_q, round_d;
    logic [255:0] vars_q, vars_d, vars_next;
    logic [255:0] digest_q, digest_d;
    logic         first_q, first_d;
    logic         busy_q, busy_d, done_q, done_d, w_ready_q, w_ready_d;

    sha256_round u_round (
        .vars_in  (vars_q),
        .w        (w_in),
        .k        (k_in),
        .vars_out (vars_next)
    );

    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        vars_d   = vars_q;
        digest_d = digest_q;
        first_d  = first_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = ROUND;
                round_d = '0;
                first_d = first_block;
                vars_d  = first_block ? IV : digest_q;
            end
            ROUND: if (w_valid) begin
                vars_d  = vars_next;
                round_d = round_q + 7'd1;
                state_d = (round_q == 7'(ROUNDS - 1)) ? FINAL : ROUND;
            end
            // The chaining value is the IV for a first block, so the IV is added
            // here rather than preloaded into digest (digest only moves in FINAL).
            FINAL: begin
                for (int i = 0; i < 8; i++)
                    digest_d[32*i +: 32] = (first_q ? IV[32*i +: 32] : digest_q[32*i +: 32]) + vars_q[32*i +: 32];
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        busy_d    = state_d != IDLE;
        done_d    = state_d == DONE;
        w_ready_d = state_d == ROUND;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            round_q   <= '0;
            vars_q    <= '0;
            digest_q  <= '0;
            first_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            w_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            vars_q    <= vars_d;
            digest_q  <= digest_d;
            first_q   <= first_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            w_ready_q <= w_ready_d;
        end
    end

    assign w_ready = w_ready_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign digest  = digest_q;
    assign round   = round_q;
endmodule

// File: tb/tb_sha256_compress.sv
// tb_sha256_compress: known-answer table plus random chained blocks against a
// whole-block SHA-256 model; covers gaps, ignored starts and mid-block reset.
module tb_sha256_compress;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0, first_block = 1'b0, w_valid = 1'b0;
    logic [31:0]  w_in = '0, k_in = '0;
    logic         w_ready, busy, done;
    logic [255:0] digest;
    logic [6:0]   round;
    int nchecks = 0, nerr = 0;

    localparam logic [255:0] H0 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_D = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [511:0] ABC_B = {32'h61626380, 448'h0, 32'h00000018};

    logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    sha256_compress #(.ROUNDS(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .first_block(first_block),
        .w_valid(w_valid), .w_in(w_in), .k_in(k_in), .w_ready(w_ready),
        .busy(busy), .done(done), .digest(digest), .round(round));

    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic expand(input logic [511:0] blk, output logic [31:0] w [64]);
        for (int t = 0; t < 64; t++)
            w[t] = (t < 16) ? blk[511 - 32*t -: 32] :
                (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7] +
                (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    endtask

    // Whole-block reference: FIPS 180-4 compression with the word-array formulation.
    task automatic model(input logic [255:0] h_in, input logic [511:0] blk, output logic [255:0] h_out);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        expand(blk, w);
        for (int i = 0; i < 8; i++) v[i] = h_in[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) h_out[255 - 32*i -: 32] = h_in[255 - 32*i -: 32] + v[i];
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, {busy, done, w_ready, round, digest}, '0);
    endtask

    // Streams one block; optionally pokes start at round 10 and in DONE, or
    // asserts reset once round abort_at is reached.
    task automatic run_block(input logic [511:0] blk, input bit first, input int gap, input bit poke,
                             input int abort_at, output logic [255:0] dig, output int lat, output int ndone);
        logic [31:0] w [64];
        int idx, after;
        bit hs, poked;
        expand(blk, w);
        idx = 0; after = 0; hs = 0; poked = 0; ndone = 0; lat = -1; dig = '0;
        @(negedge clk);
        start = 1'b1; first_block = first;
        @(negedge clk);
        first_block = 1'($urandom);
        for (int cyc = 1; cyc < 400 && after < 3; cyc++) begin
            if (hs) idx++;
            start = 1'b0;
            if (w_ready) chk("round", 256'(round), 256'(idx));
            if (abort_at >= 0 && w_ready && idx == abort_at) begin
                rst_n = 1'b0; w_valid = 1'b0;
                #1 chk_reset_outputs("reset_async");
                @(posedge clk);
                #1 chk_reset_outputs("reset_held");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (done) begin
                ndone++;
                if (ndone == 1) begin lat = cyc; dig = digest; end
                if (poke) start = 1'b1;
            end else if (ndone > 0) chk("idle_after_done", 256'(busy), 256'(0));
            if (ndone > 0) after++;
            if (poke && !poked && w_ready && idx == 10) begin
                start = 1'b1; first_block = 1'b1; poked = 1'b1;
            end
            w_valid = (idx < 64 && w_ready) ? ($urandom_range(99) >= gap) : 1'($urandom);
            w_in = (idx < 64 && w_ready) ? w[idx] : $urandom;
            k_in = (idx < 64 && w_ready) ? K[idx] : $urandom;
            hs = w_valid && w_ready;
            @(negedge clk);
        end
        start = 1'b0; w_valid = 1'b0;
        if (ndone == 0) chk("done_timeout", 256'(0), 256'(1));
    endtask

    typedef struct {
        logic [511:0] blk;
        bit           first;
        int           gap;
        bit           poke;
        bit           has_kat;
        logic [255:0] kat;
    } vec_t;

    initial begin
        vec_t tv [6];
        logic [255:0] mh, exp, dig;
        logic [511:0] blk;
        bit first;
        int gap, lat, nd;
        tv[0] = '{ABC_B, 1'b1, 0, 1'b0, 1'b1, ABC_D};
        tv[1] = '{{32'h80000000, 480'h0}, 1'b1, 0, 1'b0, 1'b1,
                  256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855};
        tv[2] = '{{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
                   32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000}, 1'b1, 0, 1'b0, 1'b0, '0};
        tv[3] = '{{480'h0, 32'h000001c0}, 1'b0, 0, 1'b0, 1'b1,
                  256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1};
        tv[4] = '{ABC_B, 1'b1, 50, 1'b0, 1'b1, ABC_D};
        tv[5] = '{ABC_B, 1'b1, 0, 1'b1, 1'b1, ABC_D};
        mh = '0;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            model(tv[i].first ? H0 : mh, tv[i].blk, mh);
            exp = tv[i].has_kat ? tv[i].kat : mh;
            run_block(tv[i].blk, tv[i].first, tv[i].gap, tv[i].poke, -1, dig, lat, nd);
            chk($sformatf("digest_v%0d", i), dig, exp);
            chk($sformatf("done_count_v%0d", i), 256'(nd), 256'(1));
            if (tv[i].gap == 0) chk($sformatf("latency_v%0d", i), 256'(lat), 256'(66));
        end

        run_block(ABC_B, 1'b1, 0, 1'b0, 30, dig, lat, nd);
        run_block(ABC_B, 1'b1, 0, 1'b0, -1, dig, lat, nd);
        chk("digest_after_reset", dig, ABC_D);
        chk("latency_after_reset", 256'(lat), 256'(66));

        for (int n = 0; n < 6; n++) begin
            for (int j = 0; j < 16; j++) blk[511 - 32*j -: 32] = $urandom;
            first = (n == 0) || ($urandom_range(3) == 0);
            gap = $urandom_range(60);
            model(first ? H0 : mh, blk, mh);
            run_block(blk, first, gap, 1'b0, -1, dig, lat, nd);
            chk($sformatf("rand_digest_%0d", n), dig, mh);
            chk($sformatf("rand_done_%0d", n), 256'(nd), 256'(1));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule

// File: doc/sha256_compress.md
SHA256_COMPRESS -- requirements
Module: sha256_compress

Interface
REQ-001 Parameter ROUNDS, default 64, SHALL set the number of compression rounds per block; only 64 is supported for SHA-256 compliance.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  in  1  SHALL be a one-cycle pulse that begins compression of one 512-bit block.
REQ-005 first_block  in  1  SHALL be sampled with start; 1 selects the FIPS 180-4 IV, 0 selects the current digest as chaining value.
REQ-006 w_valid  in  1  SHALL indicate that w_in/k_in carry the schedule word and constant for the current round.
REQ-007 w_in  in  32  SHALL be message schedule word W[t] from the upstream schedule stage.
REQ-008 k_in  in  32  SHALL be round constant K[t] from the upstream constant ROM.
REQ-009 w_ready  out  1  SHALL indicate that the block consumes a W/K pair this cycle if w_valid=1.
REQ-010 busy  out  1  SHALL be high from the cycle after an accepted start until done.
REQ-011 done  out  1  SHALL pulse high for exactly one cycle when digest is updated.
REQ-012 digest  out  256  SHALL hold H0..H7, with H0 in bits [255:224].
REQ-013 round  out  7  SHALL report the number of rounds completed in the current block (0..64).

Function
REQ-014 The FSM SHALL have states IDLE, ROUND, FINAL and DONE.
REQ-015 IDLE -> ROUND on start: a..h SHALL load from the IV or digest per first_block, and round SHALL become 0.
REQ-016 In ROUND, w_ready SHALL be 1; each cycle with w_valid=1 SHALL apply one SHA-256 round using w_in/k_in and increment round.
REQ-017 A ROUND cycle with w_valid=0 SHALL hold a..h and round unchanged; gaps of any length are legal.
REQ-018 The handshake accepting round index ROUNDS-1 SHALL move the FSM to FINAL on the next edge.
REQ-019 FINAL SHALL set each Hi <= Hi_chain + working variable (a..h), modulo 2^32 per word, then go to DONE.
REQ-020 DONE SHALL assert done for one cycle, then return to IDLE; total latency from start is ROUNDS+2 cycles with no gaps.
REQ-021 w_ready SHALL be 0 outside ROUND; w_valid outside ROUND SHALL be ignored.
REQ-022 start while busy SHALL be ignored and SHALL NOT disturb the block in progress.
REQ-023 start in the DONE cycle SHALL be ignored; start in IDLE is accepted on the cycle immediately after done.
REQ-024 All additions SHALL be 32-bit wrap-around with no carry out; Σ0, Σ1, Ch and Maj SHALL follow FIPS 180-4 exactly.
REQ-025 digest SHALL change only in FINAL, or on reset.

Reset
REQ-026 Reset low SHALL, at any time including mid-block, force IDLE, busy=0, done=0, w_ready=0, round=0, a..h=0 and digest=0.
REQ-027 After Reset deasserts, the next block SHALL use first_block=1 to obtain a valid hash.

Structure
REQ-028 Package sha256_pkg SHALL hold the word_t (32-bit) typedef, the eight IV constants, the FSM state enum and ROUNDS_DEFAULT=64.
REQ-029 One combinational sub-module, sha256_round, SHALL compute the next a..h from a..h, W and K; sha256_compress SHALL instantiate it once.

Verification
REQ-030 Stream the padded "abc" block with first_block=1 and no gaps -> digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; done occurs 66 cycles after start.
REQ-031 Stream the padded empty message -> digest=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-032 Send the two blocks of "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (second block with first_block=0) -> digest=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-033 Repeat "abc" with w_valid deasserted randomly about 50% of cycles -> identical digest; round never skips or repeats; done occurs once.
REQ-034 Assert Reset at round 30, release it, then run "abc" -> all outputs are 0 during reset, and the correct "abc" digest is produced afterward.
REQ-035 Pulse start at round 10 and again during DONE -> both pulses are ignored, and a single correct digest and single done are produced.
